vend_controller: RTL and testbench
==================================

# vend_controller

Top-level sequencing FSM for the vending machine. It accumulates coin credit, tracks per-item stock, and prices a selection through the existing `price_lookup` block, including the low-stock surcharge. It drives the dispense and change handshakes toward the mechanism front-end. All item pricing stays in `price_lookup`; this block owns credit, stock, and transaction order.

## Interface
- `INIT_STOCK`, default 4'd5: stock loaded per item at reset and on restock.
- `MAX_CREDIT`, default 8'd99: credit saturation ceiling.
- Price and surcharge parameters: passed through unchanged to `price_lookup` (defaults 3/4/6/7, threshold 2, surcharge 1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `coin_valid` in 1: one-cycle coin-insert strobe.
- `coin_value` in 4: value of the inserted coin in credit units.
- `select_valid` in 1: one-cycle selection strobe.
- `item_select` in 2: selected item, 0–3.
- `cancel` in 1: request refund of the current credit.
- `restock` in 1: reload every item's stock to `INIT_STOCK`.
- `dispense_ready` in 1: mechanism accepts the dispense.
- `change_ack` in 1: mechanism has paid out the change.
- `dispense_valid` out 1: dispense request.
- `dispense_item` out 2: item being dispensed.
- `change_valid` out 1: change request.
- `change_amount` out 8: amount of change to pay.
- `credit` out 8: current credit.
- `sold_out` out 4: per-item flag, set while that item's stock is 0.
- `err_soldout` out 1: one-cycle pulse on a sold-out selection.
- `err_insufficient` out 1: one-cycle pulse on insufficient credit.
- `coin_reject` out 1: one-cycle pulse when a coin is refused.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, PRICE, VEND, CHANGE.
- **Reset:** state IDLE, credit 0, all four stocks = `INIT_STOCK`, `item_q`/`price_q` 0. Every output is 0 except `sold_out`, which reflects stock (0 when `INIT_STOCK` > 0).
- **Coins:** accepted in IDLE and PRICE. The update is credit = min(credit + coin_value, MAX_CREDIT), computed 9 bits wide. In VEND and CHANGE a coin is refused: `coin_reject` pulses the next cycle and credit is unchanged.
- **IDLE priority** (same cycle): `cancel` > `select_valid` > `restock`. A coin arriving in the same cycle is always credited in that cycle.
- **IDLE + cancel:** if credit > 0, go to CHANGE; if credit = 0, ignore.
- **IDLE + select_valid:** latch `item_q` and go to PRICE.
- **IDLE + restock:** all stocks become `INIT_STOCK`. `restock` is ignored outside IDLE.
- **PRICE** (one cycle): `price_lookup` is driven with `item_q` and that item's stock; register `price_q`. The decision uses credit including any coin credited in this cycle:
  - stock = 0: pulse `err_soldout`, go to IDLE, credit kept.
  - credit < price: pulse `err_insufficient`, go to IDLE, credit kept.
  - otherwise: go to VEND.
- **VEND:** `dispense_valid` = 1 and `dispense_item` = `item_q`, held until `dispense_ready`. On the handshake cycle: decrement that item's stock by 1 and set credit -= `price_q`. Then go to CHANGE if the remaining credit > 0, else IDLE.
- **CHANGE:** `change_valid` = 1 and `change_amount` = credit, held stable until `change_ack`. On the handshake cycle credit becomes 0 and the state goes to IDLE.
- **Ignored inputs:** `cancel` and `select_valid` outside IDLE are ignored. They are not queued.
- **Reset mid-operation:** aborts the transaction. Credit is discarded and stock is reloaded.

## Timing
- `select_valid` in cycle t → PRICE in t+1 → `dispense_valid` or an error pulse in t+2.
- All outputs are registered; no combinational path runs from inputs to outputs.
- A handshake completes in the same cycle that `valid` and `ready`/`ack` are both high. `valid` drops the following cycle.
- Minimum vend with `dispense_ready` tied high: 3 cycles from select to back in IDLE with no change, 4 cycles with change when `change_ack` is tied high.
- `credit` reflects each coin one cycle after its `coin_valid`.

## Structure
- **Package `vend_pkg`:**
  - state enum (IDLE, PRICE, VEND, CHANGE)
  - `NUM_ITEMS = 4`
  - credit width 8, coin width 4, stock width 4
- **Sub-module:** one instance of `price_lookup`. Its parameters come through from the top level.
- **Stock storage:** an array of four 4-bit registers. A restock and a decrement never fall in the same cycle.

## Test plan
All cases use default parameters.
- **Exact payment:** coins 2, 2; select item 1 (price 4, stock 5) → `dispense_valid`, item 1 at t+2; `dispense_ready` → stock[1] = 4, credit 0, no `change_valid`, IDLE.
- **Vend with change:** coins 5, 5; select item 2 (price 6) → dispense; then `change_valid` with `change_amount` = 4, held until `change_ack`; credit 0 afterwards.
- **Insufficient then cancel:** credit 3; select item 3 (price 7) → `err_insufficient` pulse at t+2, credit stays 3; `cancel` → `change_amount` = 3.
- **Surcharge and sold-out:** vend item 0 three times (stock 5 → 2). The 4th purchase is charged 4, so with 10 credit it returns change 6. Drain stock to 0 → `sold_out[0]` = 1; selecting item 0 then pulses `err_soldout` with credit unchanged.
- **Saturation and coin reject:** seven coins of 15 → credit 99. A coin inserted during VEND → `coin_reject` pulse, credit unchanged.
- **Reset mid-transaction:** assert `rst` during VEND with `dispense_ready` low → next cycle all outputs 0, credit 0, stocks 5, state IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and widths for the vending-machine controller slice.
package vend_pkg;
  localparam int NUM_ITEMS = 4;
  localparam int CREDIT_W  = 8;
  localparam int COIN_W    = 4;
  localparam int STOCK_W   = 4;
  localparam int ITEM_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRICE,
    ST_VEND,
    ST_CHANGE
  } vend_state_e;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [STOCK_W-1:0]  stock_t;
  typedef logic [COIN_W-1:0]   coin_t;
  typedef logic [ITEM_W-1:0]   item_t;
endpackage

// File: rtl/vend_if.sv
// Front-panel and mechanism signals of the vending controller, grouped as one bundle.
interface vend_if;
  import vend_pkg::*;

  logic                 coin_valid;
  coin_t                coin_value;
  logic                 select_valid;
  item_t                item_select;
  logic                 cancel;
  logic                 restock;
  logic                 dispense_ready;
  logic                 change_ack;
  logic                 dispense_valid;
  item_t                dispense_item;
  logic                 change_valid;
  credit_t              change_amount;
  credit_t              credit;
  logic [NUM_ITEMS-1:0] sold_out;
  logic                 err_soldout;
  logic                 err_insufficient;
  logic                 coin_reject;
  logic                 busy;

  modport master (
    output coin_valid, coin_value, select_valid, item_select, cancel, restock,
           dispense_ready, change_ack,
    input  dispense_valid, dispense_item, change_valid, change_amount, credit,
           sold_out, err_soldout, err_insufficient, coin_reject, busy
  );

  modport slave (
    input  coin_valid, coin_value, select_valid, item_select, cancel, restock,
           dispense_ready, change_ack,
    output dispense_valid, dispense_item, change_valid, change_amount, credit,
           sold_out, err_soldout, err_insufficient, coin_reject, busy
  );
endinterface

// File: rtl/vend_controller_price_lookup.sv
// Combinational item pricing: base price per item plus a surcharge once stock runs low.
module price_lookup
  import vend_pkg::*;
#(
  parameter credit_t PRICE_0          = 8'd3,
  parameter credit_t PRICE_1          = 8'd4,
  parameter credit_t PRICE_2          = 8'd6,
  parameter credit_t PRICE_3          = 8'd7,
  parameter stock_t  LOW_STOCK_THRESH = 4'd2,
  parameter credit_t SURCHARGE        = 8'd1
) (
  input  item_t   item_i,
  input  stock_t  stock_i,
  output credit_t price_o
);
  credit_t base;

  always_comb begin
    base = PRICE_0;
    unique case (item_i)
      2'd0: base = PRICE_0;
      2'd1: base = PRICE_1;
      2'd2: base = PRICE_2;
      2'd3: base = PRICE_3;
    endcase
    price_o = base + ((stock_i <= LOW_STOCK_THRESH) ? SURCHARGE : '0);
  end
endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: owns credit, per-item stock and transaction order; pricing is delegated.
module vend_controller
  import vend_pkg::*;
#(
  parameter stock_t  INIT_STOCK       = 4'd5,
  parameter credit_t MAX_CREDIT       = 8'd99,
  parameter credit_t PRICE_0          = 8'd3,
  parameter credit_t PRICE_1          = 8'd4,
  parameter credit_t PRICE_2          = 8'd6,
  parameter credit_t PRICE_3          = 8'd7,
  parameter stock_t  LOW_STOCK_THRESH = 4'd2,
  parameter credit_t SURCHARGE        = 8'd1
) (
  input logic  clk,
  input logic  rst,
  vend_if.slave bus
);
  vend_state_e state_q;
  credit_t     credit_q;
  stock_t      stock_q [NUM_ITEMS];
  item_t       item_q;
  credit_t     price_q;
  logic        dispense_valid_q;
  item_t       dispense_item_q;
  logic        change_valid_q;
  credit_t     change_amount_q;
  logic        err_soldout_q;
  logic        err_insufficient_q;
  logic        coin_reject_q;

  logic                 coin_accept;
  credit_t              credit_d;
  stock_t               cur_stock;
  credit_t              lookup_price;
  credit_t              remain;
  logic [NUM_ITEMS-1:0] sold_out_w;

  // The sum is formed one bit wider so a carry out of 8 bits still saturates.
  function automatic credit_t sat_add(credit_t a, coin_t c);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, c};
    return (sum > {1'b0, MAX_CREDIT}) ? MAX_CREDIT : sum[CREDIT_W-1:0];
  endfunction

  price_lookup #(
    .PRICE_0          (PRICE_0),
    .PRICE_1          (PRICE_1),
    .PRICE_2          (PRICE_2),
    .PRICE_3          (PRICE_3),
    .LOW_STOCK_THRESH (LOW_STOCK_THRESH),
    .SURCHARGE        (SURCHARGE)
  ) u_price (
    .item_i  (item_q),
    .stock_i (cur_stock),
    .price_o (lookup_price)
  );

  assign coin_accept = bus.coin_valid && (state_q == ST_IDLE || state_q == ST_PRICE);
  assign credit_d    = coin_accept ? sat_add(credit_q, bus.coin_value) : credit_q;
  assign cur_stock   = stock_q[item_q];
  assign remain      = credit_q - price_q;

  always_comb begin
    sold_out_w = '0;
    for (int i = 0; i < NUM_ITEMS; i++) sold_out_w[i] = (stock_q[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      credit_q           <= '0;
      item_q             <= '0;
      price_q            <= '0;
      dispense_valid_q   <= 1'b0;
      dispense_item_q    <= '0;
      change_valid_q     <= 1'b0;
      change_amount_q    <= '0;
      err_soldout_q      <= 1'b0;
      err_insufficient_q <= 1'b0;
      coin_reject_q      <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= INIT_STOCK;
    end else begin
      err_soldout_q      <= 1'b0;
      err_insufficient_q <= 1'b0;
      coin_reject_q      <= bus.coin_valid && !coin_accept;
      credit_q           <= credit_d;

      unique case (state_q)
        ST_IDLE: begin
          // A coin in the same cycle as cancel is part of the refund.
          if (bus.cancel) begin
            if (credit_d != '0) begin
              state_q         <= ST_CHANGE;
              change_valid_q  <= 1'b1;
              change_amount_q <= credit_d;
            end
          end else if (bus.select_valid) begin
            item_q  <= bus.item_select;
            state_q <= ST_PRICE;
          end else if (bus.restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= INIT_STOCK;
          end
        end

        ST_PRICE: begin
          price_q <= lookup_price;
          if (cur_stock == '0) begin
            err_soldout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else if (credit_d < lookup_price) begin
            err_insufficient_q <= 1'b1;
            state_q            <= ST_IDLE;
          end else begin
            dispense_valid_q <= 1'b1;
            dispense_item_q  <= item_q;
            state_q          <= ST_VEND;
          end
        end

        ST_VEND: begin
          if (bus.dispense_ready) begin
            dispense_valid_q <= 1'b0;
            stock_q[item_q]  <= cur_stock - stock_t'(1);
            credit_q         <= remain;
            if (remain != '0) begin
              change_valid_q  <= 1'b1;
              change_amount_q <= remain;
              state_q         <= ST_CHANGE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_CHANGE: begin
          if (bus.change_ack) begin
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            credit_q        <= '0;
            state_q         <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.dispense_valid   = dispense_valid_q;
  assign bus.dispense_item    = dispense_item_q;
  assign bus.change_valid     = change_valid_q;
  assign bus.change_amount    = change_amount_q;
  assign bus.credit           = credit_q;
  assign bus.sold_out         = sold_out_w;
  assign bus.err_soldout      = err_soldout_q;
  assign bus.err_insufficient = err_insufficient_q;
  assign bus.coin_reject      = coin_reject_q;
  assign bus.busy             = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: a transaction table with a scoreboard queue, plus saturation/reject/reset sequences.
module tb_vend_controller;
  import vend_pkg::*;

  localparam int KV = 0;  // vend
  localparam int KI = 1;  // insufficient credit
  localparam int KS = 2;  // sold out
  localparam int KC = 3;  // cancel refund
  localparam int NV = 12;

  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    bit         sel;
    logic [1:0] item;
    bit         cancel;
    int         kind;
    int         chg;
    int         cred;
    int         sold;
  } vec_t;

  logic clk;
  logic rst;
  vend_if bus ();

  vend_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors;
  int   checks;
  vec_t vecs [NV];
  vec_t sb [$];
  vec_t x;
  int   n;
  int   exp_cred;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic coin(input logic [3:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_value = v;
    step();
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
  endtask

  task automatic finish_change(input int amt);
    chk("change_valid", 32'(bus.change_valid), 1);
    chk("change_amount", 32'(bus.change_amount), amt);
    step();
    chk("change_valid_held", 32'(bus.change_valid), 1);
    chk("change_amount_held", 32'(bus.change_amount), amt);
    bus.change_ack = 1'b1;
    step();
    bus.change_ack = 1'b0;
    chk("change_valid_drop", 32'(bus.change_valid), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.coin_valid     = 1'b0;
    bus.coin_value     = '0;
    bus.select_valid   = 1'b0;
    bus.item_select    = '0;
    bus.cancel         = 1'b0;
    bus.restock        = 1'b0;
    bus.dispense_ready = 1'b0;
    bus.change_ack     = 1'b0;

    //          c0     c1     sel   item  cancel kind chg cred sold
    vecs[0]  = '{4'd2, 4'd2, 1'b1, 2'd1, 1'b0, KV, 0,  0,  0};
    vecs[1]  = '{4'd5, 4'd5, 1'b1, 2'd2, 1'b0, KV, 4,  0,  0};
    vecs[2]  = '{4'd3, 4'd0, 1'b1, 2'd3, 1'b0, KI, 0,  3,  0};
    vecs[3]  = '{4'd0, 4'd0, 1'b0, 2'd0, 1'b1, KC, 3,  0,  0};
    vecs[4]  = '{4'd3, 4'd0, 1'b1, 2'd0, 1'b0, KV, 0,  0,  0};
    vecs[5]  = '{4'd3, 4'd0, 1'b1, 2'd0, 1'b0, KV, 0,  0,  0};
    vecs[6]  = '{4'd3, 4'd0, 1'b1, 2'd0, 1'b0, KV, 0,  0,  0};
    vecs[7]  = '{4'd5, 4'd5, 1'b1, 2'd0, 1'b0, KV, 6,  0,  0};
    vecs[8]  = '{4'd4, 4'd0, 1'b1, 2'd0, 1'b0, KV, 0,  0,  1};
    vecs[9]  = '{4'd5, 4'd0, 1'b1, 2'd0, 1'b0, KS, 0,  5,  1};
    vecs[10] = '{4'd0, 4'd0, 1'b0, 2'd0, 1'b1, KC, 5,  0,  1};
    vecs[11] = '{4'd15, 4'd15, 1'b1, 2'd3, 1'b0, KV, 23, 0,  1};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_dispense_valid", 32'(bus.dispense_valid), 0);
    chk("rst_change_valid", 32'(bus.change_valid), 0);
    chk("rst_sold_out", 32'(bus.sold_out), 0);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].c0 != 0) coin(vecs[v].c0);
      if (vecs[v].c1 != 0) coin(vecs[v].c1);
      if (vecs[v].sel) begin
        bus.select_valid = 1'b1;
        bus.item_select  = vecs[v].item;
        sb.push_back(vecs[v]);
        step();
        bus.select_valid = 1'b0;
        n = 1;
        do begin
          step();
          n++;
        end while (!(bus.dispense_valid || bus.err_soldout || bus.err_insufficient) && n < 12);
        chk($sformatf("v%0d_latency", v), n, 2);
      end else begin
        bus.cancel = 1'b1;
        sb.push_back(vecs[v]);
        step();
        bus.cancel = 1'b0;
      end

      x = sb.pop_front();
      case (x.kind)
        KV: begin
          chk($sformatf("v%0d_dispense_valid", v), 32'(bus.dispense_valid), 1);
          chk($sformatf("v%0d_dispense_item", v), 32'(bus.dispense_item), 32'(x.item));
          step();
          chk($sformatf("v%0d_dispense_held", v), 32'(bus.dispense_valid), 1);
          bus.dispense_ready = 1'b1;
          step();
          bus.dispense_ready = 1'b0;
          chk($sformatf("v%0d_dispense_drop", v), 32'(bus.dispense_valid), 0);
          if (x.chg != 0) finish_change(x.chg);
          else chk($sformatf("v%0d_no_change", v), 32'(bus.change_valid), 0);
        end
        KI: begin
          chk($sformatf("v%0d_err_insufficient", v), 32'(bus.err_insufficient), 1);
          chk($sformatf("v%0d_err_soldout_quiet", v), 32'(bus.err_soldout), 0);
          step();
          chk($sformatf("v%0d_err_insufficient_pulse", v), 32'(bus.err_insufficient), 0);
        end
        KS: begin
          chk($sformatf("v%0d_err_soldout", v), 32'(bus.err_soldout), 1);
          chk($sformatf("v%0d_dispense_quiet", v), 32'(bus.dispense_valid), 0);
          step();
          chk($sformatf("v%0d_err_soldout_pulse", v), 32'(bus.err_soldout), 0);
        end
        default: finish_change(x.chg);
      endcase
      chk($sformatf("v%0d_credit", v), 32'(bus.credit), x.cred);
      chk($sformatf("v%0d_busy", v), 32'(bus.busy), 0);
      chk($sformatf("v%0d_sold_out", v), 32'(bus.sold_out), x.sold);
    end

    // Restock in IDLE refills the drained item.
    bus.restock = 1'b1;
    step();
    bus.restock = 1'b0;
    chk("restock_sold_out", 32'(bus.sold_out), 0);

    // Saturation at MAX_CREDIT.
    for (int k = 0; k < 7; k++) begin
      coin(4'd15);
      exp_cred = 15 * (k + 1);
      if (exp_cred > 99) exp_cred = 99;
      chk($sformatf("sat_credit_%0d", k), 32'(bus.credit), exp_cred);
    end

    // Coin during VEND is refused while dispense waits.
    bus.select_valid = 1'b1;
    bus.item_select  = 2'd3;
    step();
    bus.select_valid = 1'b0;
    step();
    chk("vend_wait_dispense_valid", 32'(bus.dispense_valid), 1);
    bus.coin_valid = 1'b1;
    bus.coin_value = 4'd5;
    step();
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    chk("coin_reject", 32'(bus.coin_reject), 1);
    chk("reject_credit", 32'(bus.credit), 99);
    step();
    chk("coin_reject_pulse", 32'(bus.coin_reject), 0);
    chk("vend_still_waiting", 32'(bus.dispense_valid), 1);

    // Reset mid-transaction aborts everything.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_dispense_valid", 32'(bus.dispense_valid), 0);
    chk("mid_rst_dispense_item", 32'(bus.dispense_item), 0);
    chk("mid_rst_credit", 32'(bus.credit), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_change", 32'(bus.change_valid), 0);
    chk("mid_rst_change_amount", 32'(bus.change_amount), 0);
    chk("mid_rst_sold_out", 32'(bus.sold_out), 0);
    chk("mid_rst_errs", 32'({bus.err_soldout, bus.err_insufficient, bus.coin_reject}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
